// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator.
// Decodes an RV32I/RV64I instruction word into a sign-extended immediate,
// a format code and an illegal flag, and registers the result one cycle
// later. A one-entry skid buffer lets in_ready come straight from a flop.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_R    = 3'd1;
  localparam logic [2:0] FMT_I    = 3'd2;
  localparam logic [2:0] FMT_S    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_U    = 3'd5;
  localparam logic [2:0] FMT_J    = 3'd6;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] shamt;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  logic [31:0]     skid_inst;
  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_fmt;
  logic            skid_illegal;
  logic            skid_valid;

  logic            accept;
  logic            out_free;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  // Shift amount is one bit wider on RV64 (shamt[5] lives in inst[25]).
  if (XLEN == 64) begin : g_shamt64
    assign shamt = {{(XLEN-6){1'b0}}, in_inst[25:20]};
  end else begin : g_shamt32
    assign shamt = {{(XLEN-5){1'b0}}, in_inst[24:20]};
  end

  // Opcode-driven immediate decode; every sign extension copies inst[31].
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      unique case (opcode)
        7'b0000011, 7'b1100111, 7'b1110011: begin
          dec_fmt = FMT_I;
          dec_imm = {{(XLEN-11){in_inst[31]}}, in_inst[30:20]};
        end
        7'b0010011: begin
          dec_fmt = FMT_I;
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            dec_imm = shamt;
          end else begin
            dec_imm = {{(XLEN-11){in_inst[31]}}, in_inst[30:20]};
          end
        end
        7'b0100011: begin
          dec_fmt = FMT_S;
          dec_imm = {{(XLEN-11){in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
        end
        7'b1100011: begin
          dec_fmt = FMT_B;
          dec_imm = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec_fmt = FMT_U;
          dec_imm = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
        end
        7'b1101111: begin
          dec_fmt = FMT_J;
          dec_imm = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
        end
        7'b0110011: begin
          dec_fmt = FMT_R;
        end
        default: begin
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  // in_ready depends only on the skid flop, never on out_ready/in_valid.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready && !flush;
  assign out_free = !out_valid || out_ready;

  // Two-entry FIFO: output register in front, skid register behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_inst     <= '0;
      out_imm      <= '0;
      out_fmt      <= FMT_NONE;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_inst    <= '0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_illegal <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        // Older skid entry drains first; in_ready was low so nothing new arrives.
        out_valid   <= 1'b1;
        out_inst    <= skid_inst;
        out_imm     <= skid_imm;
        out_fmt     <= skid_fmt;
        out_illegal <= skid_illegal;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_inst    <= in_inst;
        out_imm     <= dec_imm;
        out_fmt     <= dec_fmt;
        out_illegal <= dec_illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_inst    <= in_inst;
      skid_imm     <= dec_imm;
      skid_fmt     <= dec_fmt;
      skid_illegal <= dec_illegal;
    end
  end

  // Saturating count of accepted illegal words; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && dec_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: three instances (RV32, RV64, 2-bit counter)
// share one stimulus stream; a queue scoreboard checks every output transfer.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_inst, a_out_imm;
  logic [2:0]  a_out_fmt;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_inst;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;
  logic [15:0] b_cnt;

  logic        c_in_ready, c_out_valid, c_out_illegal;
  logic [31:0] c_out_inst, c_out_imm;
  logic [2:0]  c_out_fmt;
  logic [1:0]  c_cnt;

  int total = 0;
  int bad   = 0;
  ent_t q[$];
  logic [15:0] m16;
  logic [1:0]  m2;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_inst(in_inst), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_inst(a_out_inst), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .illegal_cnt(a_cnt));

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_inst(in_inst), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_inst(b_out_inst), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .illegal_cnt(b_cnt));

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dutc2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(c_in_ready), .in_inst(in_inst), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_inst(c_out_inst), .out_imm(c_out_imm),
    .out_fmt(c_out_fmt), .out_illegal(c_out_illegal), .illegal_cnt(c_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode written from the instruction-format tables.
  function automatic ent_t model(input logic [31:0] i);
    ent_t   e;
    longint s;
    longint s64;
    e.inst = i;
    e.fmt  = 3'd0;
    e.ill  = 1'b0;
    s      = 0;
    s64    = 0;
    if (i[1:0] != 2'b11) begin
      e.ill = 1'b1;
    end else begin
      case (i[6:0])
        7'h03, 7'h67, 7'h73: begin e.fmt = 3'd2; s = longint'($signed(i[31:20])); s64 = s; end
        7'h13: begin
          e.fmt = 3'd2;
          if (i[13:12] == 2'b01) begin
            s   = longint'(i[24:20]);
            s64 = longint'(i[25:20]);
          end else begin
            s = longint'($signed(i[31:20])); s64 = s;
          end
        end
        7'h23: begin e.fmt = 3'd3; s = longint'($signed({i[31:25], i[11:7]})); s64 = s; end
        7'h63: begin e.fmt = 3'd4; s = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); s64 = s; end
        7'h37, 7'h17: begin e.fmt = 3'd5; s = longint'($signed({i[31:12], 12'b0})); s64 = s; end
        7'h6F: begin e.fmt = 3'd6; s = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); s64 = s; end
        7'h33: begin e.fmt = 3'd1; end
        default: e.ill = 1'b1;
      endcase
    end
    e.imm32 = s[31:0];
    e.imm64 = s64;
    return e;
  endfunction

  // Scoreboard: outputs checked before the edge that transfers them;
  // accepted inputs pushed before the edge that captures them.
  always @(negedge clk) begin
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m16 = '0;
      m2  = '0;
    end else begin
      chk("cnt32", 64'(a_cnt), 64'(m16));
      chk("cnt64", 64'(b_cnt), 64'(m16));
      chk("cnt_w2", 64'(c_cnt), 64'(m2));
      if (a_out_valid && out_ready) begin
        chk("sb_has_entry", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          $display("out inst=%h imm32=%h imm64=%h fmt=%0d ill=%0b",
                   a_out_inst, a_out_imm, b_out_imm, a_out_fmt, a_out_illegal);
          chk("sb_inst", 64'(a_out_inst), 64'(e.inst));
          chk("sb_imm32", 64'(a_out_imm), 64'(e.imm32));
          chk("sb_fmt", 64'(a_out_fmt), 64'(e.fmt));
          chk("sb_ill", 64'(a_out_illegal), 64'(e.ill));
          chk("sb_imm64", b_out_imm, e.imm64);
          chk("sb_c2_inst", 64'(c_out_inst), 64'(e.inst));
        end
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && a_in_ready) begin
        e = model(in_inst);
        q.push_back(e);
        if (e.ill) begin
          if (m16 != 16'hFFFF) m16 = m16 + 16'd1;
          if (m2 != 2'd3) m2 = m2 + 2'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    in_valid = 1'b1;
    in_inst  = w;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_inst", 64'(a_out_inst), 64'd0);
    chk("rst_imm", b_out_imm, 64'd0);
    chk("rst_fmt", 64'(a_out_fmt), 64'd0);
    chk("rst_ill", 64'(a_out_illegal), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Decode, out_ready high
    push(32'hFFC12083);
    chk("lat_valid", 64'(a_out_valid), 64'd1);
    chk("ld_imm", 64'(a_out_imm), 64'hFFFFFFFC);
    chk("ld_fmt", 64'(a_out_fmt), 64'd2);
    push(32'hFE000CE3);
    chk("b_imm", 64'(a_out_imm), 64'hFFFFFFF8);
    chk("b_fmt", 64'(a_out_fmt), 64'd4);
    push(32'h0010006F);
    chk("j_imm", 64'(a_out_imm), 64'h00000800);
    chk("j_fmt", 64'(a_out_fmt), 64'd6);
    push(32'h4030D093);
    chk("srai_imm", 64'(a_out_imm), 64'd3);
    push(32'h123450B7);
    chk("lui_imm", 64'(a_out_imm), 64'h12345000);
    chk("lui_fmt", 64'(a_out_fmt), 64'd5);
    push(32'h800000B7);
    chk("lui64_imm", b_out_imm, 64'hFFFFFFFF80000000);
    push(32'h03F0D093);
    chk("sh64_imm", b_out_imm, 64'd63);
    chk("sh32_imm", 64'(a_out_imm), 64'd31);
    push(32'hFE112E23);
    push(32'h00B50533);
    chk("r_fmt", 64'(a_out_fmt), 64'd1);

    // Illegal words and counter saturation
    push(32'h00000000);
    chk("ill0_flag", 64'(a_out_illegal), 64'd1);
    chk("ill0_fmt", 64'(a_out_fmt), 64'd0);
    chk("ill0_imm", 64'(a_out_imm), 64'd0);
    push(32'h0000007F);
    chk("ill7f_flag", 64'(a_out_illegal), 64'd1);
    chk("ill7f_imm", b_out_imm, 64'd0);
    chk("ill_cnt2", 64'(a_cnt), 64'd2);
    push(32'h00000002);
    push(32'h0000007F);
    push(32'h00000000);
    tick();
    chk("cnt_sat_w2", 64'(c_cnt), 64'd3);
    chk("cnt_5", 64'(a_cnt), 64'd5);

    // Backpressure: A, B held, C waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00500093; tick();
    chk("bp_a_out", 64'(a_out_inst), 64'h00500093);
    chk("bp_a_rdy", 64'(a_in_ready), 64'd1);
    in_inst = 32'hFE112E23; tick();
    chk("bp_b_rdy", 64'(a_in_ready), 64'd0);
    chk("bp_b_hold", 64'(a_out_inst), 64'h00500093);
    in_inst = 32'h0010006F; tick();
    chk("bp_c_rdy", 64'(a_in_ready), 64'd0);
    chk("bp_c_hold", 64'(a_out_inst), 64'h00500093);
    out_ready = 1'b1; tick();
    chk("bp_out_b", 64'(a_out_inst), 64'hFE112E23);
    chk("bp_rdy_back", 64'(a_in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_out_c", 64'(a_out_inst), 64'h0010006F);
    chk("bp_out_c_valid", 64'(a_out_valid), 64'd1);
    tick();
    chk("bp_drained", 64'(a_out_valid), 64'd0);

    // Flush with both entries full and an illegal word presented
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00000013; tick();
    in_inst = 32'h00100113; tick();
    flush = 1'b1; in_inst = 32'h00000000; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(a_out_valid), 64'd0);
    chk("fl_rdy", 64'(a_in_ready), 64'd1);
    chk("fl_cnt", 64'(a_cnt), 64'd5);
    out_ready = 1'b1; tick();
    chk("fl_no_word", 64'(a_out_valid), 64'd0);
    // Flush with room to accept: word still dropped and not counted
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0000007F; tick();
    flush = 1'b0; in_valid = 1'b0; tick();
    chk("fl2_valid", 64'(a_out_valid), 64'd0);
    chk("fl2_cnt", 64'(a_cnt), 64'd5);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFC12083; tick();
    in_inst = 32'h00000000; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(a_out_valid), 64'd0);
    chk("ar_rdy", 64'(a_in_ready), 64'd1);
    chk("ar_inst", 64'(a_out_inst), 64'd0);
    chk("ar_imm", b_out_imm, 64'd0);
    chk("ar_fmt", 64'(a_out_fmt), 64'd0);
    chk("ar_cnt", 64'(a_cnt), 64'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    push(32'h123450B7);
    chk("ar_resume", 64'(a_out_imm), 64'h12345000);
    push(32'hFE000CE3);
    push(32'h00000000);
    repeat (3) tick();
    chk("ar_cnt_after", 64'(a_cnt), 64'd1);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
